// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD SPI-mode link: command indices, R1 bit
// positions, response kinds and the card responder FSM states.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ILLEGAL_BIT = 2;
  localparam int R1_CRC_BIT     = 3;

  typedef enum logic [1:0] {RESP_R1, RESP_R3, RESP_R7} resp_kind_e;

  typedef enum logic [2:0] {ST_IDLE, ST_HUNT, ST_RECV, ST_NCR, ST_RESP} state_e;

  // Number of response bits shifted out for each response kind.
  function automatic logic [6:0] resp_bits(input resp_kind_e kind);
    return (kind == RESP_R1) ? 7'd8 : 7'd40;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first data. clear restarts the sum; with
// enable in the same cycle, the first bit is folded into a fresh sum.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_reg;
  logic [6:0] base;
  logic [6:0] stepped;

  always_comb begin
    base    = clear ? 7'h00 : crc_reg;
    stepped = {base[5:0], 1'b0} ^ ((base[6] ^ din) ? 7'h09 : 7'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg <= 7'h00;
    end else if (enable) begin
      crc_reg <= stepped;
    end else if (clear) begin
      crc_reg <= 7'h00;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SD SPI-mode responder answering CMD0/CMD8/CMD55/ACMD41/CMD58.
// Define SD_SPI_CARD_RESPONDER_CRC_ALL_EN to CRC-check every frame, not just CMD0/CMD8.
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int          NCR_BYTES         = 2,
  parameter int          ACMD41_BUSY_COUNT = 3,
  parameter logic [31:0] OCR_VALUE         = 32'hC0FF_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cclk,
  input  logic        sd_cmd,
  input  logic        sd_cs,
  output logic        sd_data,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  logic [1:0] sclk_sync_reg, cs_sync_reg, cmd_sync_reg;
  logic       sclk_prev_reg;
  logic       sclk_s, cs_s, mosi, rise, fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_reg <= 2'b00;
      cs_sync_reg   <= 2'b11;
      cmd_sync_reg  <= 2'b11;
      sclk_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], sd_cclk};
      cs_sync_reg   <= {cs_sync_reg[0], sd_cs};
      cmd_sync_reg  <= {cmd_sync_reg[0], sd_cmd};
      sclk_prev_reg <= sclk_sync_reg[1];
    end
  end

  assign sclk_s = sclk_sync_reg[1];
  assign cs_s   = cs_sync_reg[1];
  assign mosi   = cmd_sync_reg[1];
  assign rise   = !sclk_prev_reg && sclk_s;
  assign fall   = sclk_prev_reg && !sclk_s;

  state_e      state_reg, state_next;
  resp_kind_e  resp_kind_reg, resp_kind_next;
  logic [47:0] shift_reg, shift_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic        start_seen_reg, start_seen_next;
  logic [39:0] resp_reg, resp_next;
  logic        sd_data_reg, sd_data_next;
  logic        cmd_valid_reg, cmd_valid_next;
  logic [5:0]  cmd_index_reg, cmd_index_next;
  logic [31:0] cmd_arg_reg, cmd_arg_next;
  logic        card_ready_reg, card_ready_next;
  logic        spi_mode_reg, spi_mode_next;
  logic        idle_reg, idle_next;
  logic        pend_reg, pend_next;
  logic [7:0]  acnt_reg, acnt_next;

  logic        crc_clear, crc_en;
  logic [6:0]  crc_val;
  logic [5:0]  f_index;
  logic [31:0] f_arg;
  logic        frame_ok, crc_checked, crc_err;
  logic        illegal, idle_new, answer;
  logic [7:0]  r1;
  logic [31:0] payload;
  resp_kind_e  kind;

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (mosi),
    .crc    (crc_val)
  );

  assign f_index  = shift_reg[45:40];
  assign f_arg    = shift_reg[39:8];
  assign frame_ok = shift_reg[0] && !shift_reg[47] && shift_reg[46];

`ifdef SD_SPI_CARD_RESPONDER_CRC_ALL_EN
  assign crc_checked = 1'b1;
`else
  assign crc_checked = (f_index == CMD0) || (f_index == CMD8);
`endif
  assign crc_err = crc_checked && (crc_val != shift_reg[7:1]);

  always_comb begin
    state_next      = state_reg;
    resp_kind_next  = resp_kind_reg;
    shift_next      = shift_reg;
    cnt_next        = cnt_reg;
    start_seen_next = start_seen_reg;
    resp_next       = resp_reg;
    sd_data_next    = sd_data_reg;
    cmd_valid_next  = 1'b0;
    cmd_index_next  = cmd_index_reg;
    cmd_arg_next    = cmd_arg_reg;
    card_ready_next = card_ready_reg;
    spi_mode_next   = spi_mode_reg;
    idle_next       = idle_reg;
    pend_next       = pend_reg;
    acnt_next       = acnt_reg;
    crc_clear       = 1'b0;
    crc_en          = 1'b0;
    illegal         = 1'b0;
    idle_new        = idle_reg;
    answer          = 1'b0;
    kind            = RESP_R1;
    payload         = 32'h0;
    r1              = 8'h00;

    if (cs_s) begin
      state_next   = ST_IDLE;
      sd_data_next = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          sd_data_next    = 1'b1;
          start_seen_next = 1'b0;
          state_next      = ST_HUNT;
        end
        ST_HUNT: begin
          if (fall) sd_data_next = 1'b1;
          if (rise) begin
            shift_next = {shift_reg[46:0], mosi};
            if (start_seen_reg && mosi) begin
              // Transmission bit is the first bit that enters the CRC.
              state_next = ST_RECV;
              cnt_next   = 7'd2;
              crc_clear  = 1'b1;
              crc_en     = 1'b1;
            end else begin
              start_seen_next = !mosi;
            end
          end
        end
        ST_RECV: begin
          if (fall) sd_data_next = 1'b1;
          if (cnt_reg == 7'd48) begin
            if (!frame_ok) begin
              state_next      = ST_HUNT;
              start_seen_next = 1'b0;
            end else begin
              cmd_valid_next = 1'b1;
              cmd_index_next = f_index;
              cmd_arg_next   = f_arg;
              answer         = spi_mode_reg || (f_index == CMD0);
              if (!crc_err) begin
                case (f_index)
                  CMD0: begin
                    spi_mode_next   = 1'b1;
                    idle_new        = 1'b1;
                    card_ready_next = 1'b0;
                    acnt_next       = 8'd0;
                  end
                  CMD8: begin
                    kind    = RESP_R7;
                    payload = (f_arg[11:8] == 4'h1) ? {20'h0, f_arg[11:0]} : 32'h0;
                  end
                  CMD55: ;
                  CMD41: begin
                    if (!pend_reg) begin
                      illegal = 1'b1;
                    end else if (acnt_reg < 8'(ACMD41_BUSY_COUNT)) begin
                      acnt_next = acnt_reg + 8'd1;
                    end else begin
                      idle_new        = 1'b0;
                      card_ready_next = 1'b1;
                    end
                  end
                  CMD58: begin
                    kind    = RESP_R3;
                    payload = {OCR_VALUE[31] & !idle_new, OCR_VALUE[30:0]};
                  end
                  default: illegal = 1'b1;
                endcase
              end
              pend_next                 = spi_mode_reg && (f_index == CMD55) && !crc_err;
              idle_next                 = idle_new;
              r1[R1_IDLE_BIT]           = idle_new;
              r1[R1_ILLEGAL_BIT]        = illegal;
              r1[R1_CRC_BIT]            = crc_err;
              resp_next                 = {r1, payload};
              resp_kind_next            = kind;
              cnt_next                  = 7'd0;
              start_seen_next           = 1'b0;
              state_next                = answer ? ST_NCR : ST_HUNT;
            end
          end else if (rise) begin
            shift_next = {shift_reg[46:0], mosi};
            cnt_next   = cnt_reg + 7'd1;
            crc_en     = (cnt_reg <= 7'd39);
          end
        end
        ST_NCR: begin
          if (fall) begin
            sd_data_next = 1'b1;
            if (cnt_reg == 7'(NCR_BYTES * 8 - 1)) begin
              state_next = ST_RESP;
              cnt_next   = 7'd0;
            end else begin
              cnt_next = cnt_reg + 7'd1;
            end
          end
        end
        ST_RESP: begin
          if (fall) begin
            sd_data_next = resp_reg[39];
            resp_next    = {resp_reg[38:0], 1'b0};
            if (cnt_reg == resp_bits(resp_kind_reg) - 7'd1) begin
              state_next      = ST_HUNT;
              start_seen_next = 1'b0;
              cnt_next        = 7'd0;
            end else begin
              cnt_next = cnt_reg + 7'd1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      resp_kind_reg  <= RESP_R1;
      shift_reg      <= '1;
      cnt_reg        <= 7'd0;
      start_seen_reg <= 1'b0;
      resp_reg       <= 40'h0;
      sd_data_reg    <= 1'b1;
      cmd_valid_reg  <= 1'b0;
      cmd_index_reg  <= 6'd0;
      cmd_arg_reg    <= 32'h0;
      card_ready_reg <= 1'b0;
      spi_mode_reg   <= 1'b0;
      idle_reg       <= 1'b1;
      pend_reg       <= 1'b0;
      acnt_reg       <= 8'd0;
    end else begin
      state_reg      <= state_next;
      resp_kind_reg  <= resp_kind_next;
      shift_reg      <= shift_next;
      cnt_reg        <= cnt_next;
      start_seen_reg <= start_seen_next;
      resp_reg       <= resp_next;
      sd_data_reg    <= sd_data_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_index_reg  <= cmd_index_next;
      cmd_arg_reg    <= cmd_arg_next;
      card_ready_reg <= card_ready_next;
      spi_mode_reg   <= spi_mode_next;
      idle_reg       <= idle_next;
      pend_reg       <= pend_next;
      acnt_reg       <= acnt_next;
    end
  end

  assign sd_data    = sd_data_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign cmd_index  = cmd_index_reg;
  assign cmd_arg    = cmd_arg_reg;
  assign card_ready = card_ready_reg;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench: drives host SPI frames and compares MISO bytes against a
// card-state model of the SD SPI init sequence.
module tb_sd_spi_card_responder;

  localparam int          NCR  = 2;
  localparam int          BUSY = 3;
  localparam logic [31:0] OCR  = 32'hC0FF_8000;
  localparam int          HALF = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sd_cclk = 1'b0;
  logic        sd_cmd = 1'b1;
  logic        sd_cs = 1'b1;
  logic        sd_data, cmd_valid, card_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  always #5 clk = ~clk;

  sd_spi_card_responder #(
    .NCR_BYTES(NCR), .ACMD41_BUSY_COUNT(BUSY), .OCR_VALUE(OCR)
  ) dut (
    .clk(clk), .reset(reset), .sd_cclk(sd_cclk), .sd_cmd(sd_cmd), .sd_cs(sd_cs),
    .sd_data(sd_data), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .card_ready(card_ready)
  );

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int cs_hi_cnt = 0;
  logic prev_valid = 1'b0;
  logic [5:0]  cap_idx = 6'd0;
  logic [31:0] cap_arg = 32'h0;

  // Card model state
  bit m_spi, m_idle, m_ready, m_pend;
  int m_cnt;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: cmd_valid must be a single-cycle pulse, MISO idles high
  // whenever chip select has been high long enough to pass the synchronizer.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) begin
        vcount++;
        cap_idx = cmd_index;
        cap_arg = cmd_arg;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL cmd_valid_width: got 2+ cycles expected 1");
        end
      end
      if (cs_hi_cnt >= 4) begin
        checks++;
        if (sd_data !== 1'b1) begin
          errors++;
          $display("FAIL miso_cs_high: got %b expected 1", sd_data);
        end
      end
    end
    prev_valid = cmd_valid;
    cs_hi_cnt  = sd_cs ? cs_hi_cnt + 1 : 0;
  end

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_spi = 0; m_idle = 1; m_ready = 0; m_pend = 0; m_cnt = 0;
  endtask

  task automatic model_frame(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok);
    bit err, illegal;
    int npay;
    logic [31:0] pay;
    exp_q.delete();
    if (!m_spi && idx != 6'd0) begin
      m_pend = 0;
      return;
    end
    err = (idx == 6'd0 || idx == 6'd8) && !crc_ok;
    illegal = 0; npay = 0; pay = 32'h0;
    if (!err) begin
      if (idx == 6'd0) begin
        m_spi = 1; m_idle = 1; m_ready = 0; m_cnt = 0;
      end else if (idx == 6'd8) begin
        npay = 4;
        pay  = (arg[11:8] == 4'h1) ? {20'h0, arg[11:0]} : 32'h0;
      end else if (idx == 6'd55) begin
        npay = 0;
      end else if (idx == 6'd41 && m_pend) begin
        if (m_cnt < BUSY) m_cnt++;
        else begin m_idle = 0; m_ready = 1; end
      end else if (idx == 6'd58) begin
        npay = 4;
        pay  = OCR;
        if (m_idle) pay[31] = 1'b0;
      end else begin
        illegal = 1;
      end
    end
    m_pend = (idx == 6'd55) && !err;
    exp_q.push_back({4'b0, err, illegal, 1'b0, m_idle});
    for (int i = 3; i >= 0; i--)
      if (i < npay) exp_q.push_back(pay[i*8 +: 8]);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    sd_cclk = 1'b0;
    sd_cmd  = b;
    repeat (HALF) @(negedge clk);
    m = sd_data;
    sd_cclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_bits(input logic [47:0] f, input int n);
    logic m;
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    for (int i = 47; i > 47 - n; i--) spi_bit(f[i], m);
  endtask

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg,
                                             input bit bad_crc);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, (bad_crc ? 7'h00 : crc7(body)), 1'b1};
  endfunction

  task automatic xfer(input string name, input logic [5:0] idx, input logic [31:0] arg,
                      input bit bad_crc, input int lit_n, input logic [39:0] lit);
    int v0, pos;
    logic [63:0] exp_bits, got;
    logic [39:0] mq;
    logic m;
    v0 = vcount;
    model_frame(idx, arg, !bad_crc);
    mq = 40'h0;
    foreach (exp_q[i]) mq = {mq[31:0], exp_q[i]};
    check({name, "_model"}, {24'(exp_q.size()), mq}, {24'(lit_n), lit});
    exp_bits = '1;
    pos = 63 - NCR * 8;
    foreach (exp_q[i])
      for (int b = 7; b >= 0; b--) begin
        exp_bits[pos] = exp_q[i][b];
        pos--;
      end
    sd_cs = 1'b0;
    send_bits(make_frame(idx, arg, bad_crc), 48);
    for (int k = 0; k < 64; k++) begin
      spi_bit(1'b1, m);
      got[63-k] = m;
    end
    sd_cs = 1'b1;
    repeat (8) @(negedge clk);
    check({name, "_strobe"}, 64'(vcount - v0), 64'd1);
    check({name, "_index"}, 64'(cap_idx), 64'(idx));
    check({name, "_arg"}, 64'(cap_arg), 64'(arg));
    check({name, "_miso"}, got, exp_bits);
    check({name, "_ready"}, 64'(card_ready), 64'(m_ready));
    $display("xfer %-10s idx=%0d arg=%h miso=%h expected=%h ready=%b",
             name, idx, arg, got, exp_bits, card_ready);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pre;
    logic m;
    int v0;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sd_data", 64'(sd_data), 64'd1);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_index", 64'(cmd_index), 64'd0);
    check("rst_cmd_arg", 64'(cmd_arg), 64'd0);
    check("rst_card_ready", 64'(card_ready), 64'd0);
    check("crc_cmd0", 64'(crc7(40'h40_0000_0000)), 64'h4A);
    check("crc_cmd8", 64'(crc7(40'h48_0000_01AA)), 64'h43);
    $display("reset state sampled");

    xfer("cmd0", 6'd0, 32'h0, 0, 1, 40'h01);
    xfer("cmd8", 6'd8, 32'h0000_01AA, 0, 5, 40'h01_0000_01AA);
    xfer("cmd8_badcrc", 6'd8, 32'h0000_01AA, 1, 1, 40'h09);
    for (int i = 0; i < 4; i++) begin
      xfer("cmd55", 6'd55, 32'h0, 0, 1, 40'h01);
      xfer("acmd41", 6'd41, 32'h4000_0000, 0, 1, (i < 3) ? 40'h01 : 40'h00);
    end
    xfer("cmd58", 6'd58, 32'h0, 0, 5, 40'h00_C0FF_8000);

    // Reset while the R1 of a CMD58 is being shifted out.
    v0 = vcount;
    sd_cs = 1'b0;
    send_bits(make_frame(6'd58, 32'h0, 0), 48);
    for (int k = 0; k < 20; k++) begin
      spi_bit(1'b1, m);
      pre[19-k] = m;
    end
    sd_cclk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("midresp_prefix", 64'(pre), 64'hFFFF0);
    check("midresp_miso", 64'(sd_data), 64'd0);
    check("midresp_ready", 64'(card_ready), 64'd1);
    check("midresp_strobe", 64'(vcount - v0), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_sd_data", 64'(sd_data), 64'd1);
    check("rst_mid_ready", 64'(card_ready), 64'd0);
    $display("reset mid-response sd_data=%b card_ready=%b", sd_data, card_ready);
    sd_cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);

    xfer("cmd58_nomode", 6'd58, 32'h0, 0, 0, 40'h0);
    xfer("cmd0_again", 6'd0, 32'h0, 0, 1, 40'h01);
    xfer("cmd17", 6'd17, 32'h0000_0200, 0, 1, 40'h05);
    xfer("cmd41_alone", 6'd41, 32'h4000_0000, 0, 1, 40'h05);

    // Partial frame aborted by chip select.
    v0 = vcount;
    sd_cs = 1'b0;
    send_bits(make_frame(6'd0, 32'h0, 0), 20);
    sd_cs = 1'b1;
    repeat (8) @(negedge clk);
    check("partial_miso", 64'(sd_data), 64'd1);
    check("partial_strobe", 64'(vcount - v0), 64'd0);
    $display("partial frame aborted sd_data=%b strobes=%0d", sd_data, vcount - v0);
    xfer("cmd0_after", 6'd0, 32'h0, 0, 1, 40'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
